// File: rtl/uart_pkg.sv
// Shared definitions for the uart_fifo_n block: parity-mode encodings,
// RX/TX state enums, rx_err bit positions and the parity helper used by
// both the receiver check and the transmitter generator.
package uart_pkg;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_STICK = 2'b11;

    localparam int ERR_FRAMING = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_OVERRUN = 2;
    localparam int ERR_BREAK   = 3;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK_WAIT
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    // Parity bit value that goes with a character whose XOR-reduction is data_xor.
    function automatic logic exp_parity(input logic [1:0] mode, input logic stick,
                                        input logic data_xor);
        case (mode)
            PAR_ODD:  return ~data_xor;
            PAR_EVEN: return data_xor;
            default:  return stick;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy level and a registered head word.
// Ports: push_i/din_i write, pop_i read (ignored when empty), head_o current
// head (registered), full_o/empty_o flags, level_o occupancy 0..DEPTH.
// A push while full is dropped unless a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] head_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = head_q;
    assign level_o = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            // Head follows the next-state storage so it matches a direct read.
            head_q   <= mem_d[rd_ptr_d];
        end
    end

endmodule

// File: rtl/uart_fifo_n.sv
// UART with RX/TX FIFOs, configurable width, parity and stop bits.
// Ports: clk/reset; rxd (async serial in) / txd (registered serial out);
// baudrate (bit = baudrate+1 clocks), parity_mode, stick_bit, two_stop;
// rx_en/tx_en; TX FIFO: txdata, write_tx, tx_full, tx_level, tx_busy;
// RX FIFO: rxdata, rx_valid, read_rx, rx_level;
// rx_err = {break, overrun (sticky), parity, framing (head entry)}; clear_err.
//
// state         | meaning
// RX_IDLE       | waiting for a synchronised falling edge
// RX_START      | checking start bit at mid-bit
// RX_DATA       | sampling DATA_W bits, LSB first
// RX_PARITY     | sampling/checking the parity bit
// RX_STOP       | sampling stop bit, push or flag break
// RX_BREAK_WAIT | line held low after break, wait for rxd=1
// TX_IDLE       | txd=1, pop when enabled and FIFO non-empty
// TX_START..    | START/DATA/PARITY/STOP1/STOP2 each held baudrate+1 clocks
module uart_fifo_n import uart_pkg::*; #(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rxd,
    output logic                        txd,
    input  logic [CNT_W-1:0]            baudrate,
    input  logic [1:0]                  parity_mode,
    input  logic                        stick_bit,
    input  logic                        two_stop,
    input  logic                        rx_en,
    input  logic                        tx_en,
    input  logic [DATA_W-1:0]           txdata,
    input  logic                        write_tx,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic                        tx_busy,
    output logic [DATA_W-1:0]           rxdata,
    output logic                        rx_valid,
    input  logic                        read_rx,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [3:0]                  rx_err,
    input  logic                        clear_err
);
    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    // ---------------- receiver ----------------
    logic              rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_t         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_perr_q, rx_perr_d;
    logic              rx_zero_q, rx_zero_d;
    logic              rx_mid, rx_push, rx_ferr, brk_set, ovr_set;
    logic [DATA_W+1:0] rx_head;
    logic              rx_full, rx_empty;
    logic [1:0]        sticky_q, sticky_d;

    assign rx_mid = (rx_cnt_q == (baudrate >> 1));

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = (rx_cnt_q == baudrate) ? '0 : rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_zero_d  = rx_zero_q;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        brk_set    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_en && rx_s3_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_bit_d   = '0;
                    rx_perr_d  = 1'b0;
                    rx_zero_d  = 1'b1;
                end
            end
            RX_START: if (rx_mid) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            RX_DATA: if (rx_mid) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
                rx_zero_d  = rx_zero_q & ~rx_s2_q;
                rx_bit_d   = rx_bit_q + 1'b1;
                if (rx_bit_q == LAST_BIT)
                    rx_state_d = (parity_mode == PAR_NONE) ? RX_STOP : RX_PARITY;
            end
            RX_PARITY: if (rx_mid) begin
                rx_perr_d  = rx_s2_q != exp_parity(parity_mode, stick_bit, ^rx_shift_q);
                rx_zero_d  = rx_zero_q & ~rx_s2_q;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_mid) begin
                if (rx_zero_q && !rx_s2_q) begin
                    brk_set    = 1'b1;
                    rx_state_d = RX_BREAK_WAIT;
                end else begin
                    rx_push    = 1'b1;
                    rx_ferr    = ~rx_s2_q;
                    rx_state_d = RX_IDLE;
                end
            end
            RX_BREAK_WAIT: if (rx_s2_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
        // Disabling the receiver drops any frame in flight.
        if (!rx_en && rx_state_q != RX_IDLE) begin
            rx_state_d = RX_IDLE;
            rx_push    = 1'b0;
            brk_set    = 1'b0;
        end
    end

    assign ovr_set = rx_push & rx_full & ~read_rx;

    always_comb begin
        sticky_d = sticky_q;
        if (clear_err) sticky_d = '0;
        if (brk_set) sticky_d[1] = 1'b1;
        if (ovr_set) sticky_d[0] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_zero_q  <= 1'b0;
            sticky_q   <= '0;
        end else begin
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            rx_zero_q  <= rx_zero_d;
            sticky_q   <= sticky_d;
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_W + 2), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .din_i   ({rx_perr_q, rx_ferr, rx_shift_q}),
        .pop_i   (read_rx),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    assign rx_valid = ~rx_empty;
    assign rxdata   = rx_head[DATA_W-1:0];
    assign rx_err   = {sticky_q, rx_valid ? rx_head[DATA_W+1:DATA_W] : 2'b00};

    // ---------------- transmitter ----------------
    tx_state_t         tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_par_q, tx_par_d;
    logic              txd_q, txd_d;
    logic              tx_end, tx_load, tx_empty;
    logic [DATA_W-1:0] tx_head;

    assign tx_end = (tx_cnt_q == baudrate);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_end ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_load  = tx_en && !tx_empty;
            end
            TX_START: if (tx_end) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
            end
            TX_DATA: if (tx_end) begin
                if (tx_bit_q == LAST_BIT) begin
                    tx_state_d = (parity_mode == PAR_NONE) ? TX_STOP1 : TX_PARITY;
                end else begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 1'b1;
                end
            end
            TX_PARITY: if (tx_end) tx_state_d = TX_STOP1;
            TX_STOP1: if (tx_end) begin
                if (two_stop) begin
                    tx_state_d = TX_STOP2;
                end else begin
                    tx_state_d = TX_IDLE;
                    tx_load    = tx_en && !tx_empty;
                end
            end
            TX_STOP2: if (tx_end) begin
                tx_state_d = TX_IDLE;
                tx_load    = tx_en && !tx_empty;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Loading straight from the last stop bit gives back-to-back frames.
        if (tx_load) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_head;
            tx_par_d   = exp_parity(parity_mode, stick_bit, ^tx_head);
        end
        case (tx_state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = tx_shift_d[0];
            TX_PARITY: txd_d = tx_par_d;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (write_tx),
        .din_i   (txdata),
        .pop_i   (tx_load),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    assign txd     = txd_q;
    assign tx_busy = (tx_state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_fifo_n.sv
// Directed bench for uart_fifo_n: RX results go through a scoreboard queue
// filled when frames are driven and drained when rx_valid shows a word.
module tb_uart_fifo_n;
    localparam int DATA_W   = 8;
    localparam int RX_DEPTH = 4;
    localparam int TX_DEPTH = 8;
    localparam int CNT_W    = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      rxd, rxd_drv, loop_en, txd;
    logic [CNT_W-1:0]          baudrate;
    logic [1:0]                parity_mode;
    logic                      stick_bit, two_stop, rx_en, tx_en;
    logic [DATA_W-1:0]         txdata;
    logic                      write_tx, tx_full, tx_busy;
    logic [$clog2(TX_DEPTH):0] tx_level;
    logic [DATA_W-1:0]         rxdata;
    logic                      rx_valid, read_rx, clear_err;
    logic [$clog2(RX_DEPTH):0] rx_level;
    logic [3:0]                rx_err;

    always #5 clk = ~clk;
    assign rxd = loop_en ? txd : rxd_drv;

    uart_fifo_n #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .txd(txd), .baudrate(baudrate),
        .parity_mode(parity_mode), .stick_bit(stick_bit), .two_stop(two_stop),
        .rx_en(rx_en), .tx_en(tx_en), .txdata(txdata), .write_tx(write_tx),
        .tx_full(tx_full), .tx_level(tx_level), .tx_busy(tx_busy),
        .rxdata(rxdata), .rx_valid(rx_valid), .read_rx(read_rx),
        .rx_level(rx_level), .rx_err(rx_err), .clear_err(clear_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [DATA_W+1:0] sb_q[$];   // {parity_err, framing_err, data}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd_drv = b;
        tick(16);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rxd_drv = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [DATA_W+1:0] e;
        int t;
        t = 0;
        while (!rx_valid && t < 600) begin tick(); t++; end
        chk({tag, "_valid"}, rx_valid, 1);
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = 'x;
        chk({tag, "_data"}, rxdata, e[DATA_W-1:0]);
        chk({tag, "_err"}, rx_err[1:0], e[DATA_W+1:DATA_W]);
        read_rx = 1'b1;
        tick();
        read_rx = 1'b0;
    endtask

    task automatic wait_tx_idle(input string tag);
        int t;
        t = 0;
        while (tx_busy && t < 4000) begin tick(); t++; end
        chk(tag, tx_busy, 0);
    endtask

    initial begin
        logic [9:0]        frame;
        logic [DATA_W+1:0] e;
        int t, busy_cnt, n_rd;
        logic started, done;

        reset = 1'b0; rxd_drv = 1'b1; loop_en = 1'b0; baudrate = 16'd15;
        parity_mode = 2'b00; stick_bit = 1'b0; two_stop = 1'b0;
        rx_en = 1'b1; tx_en = 1'b1; txdata = '0; write_tx = 1'b0;
        read_rx = 1'b0; clear_err = 1'b0;
        #2 reset = 1'b1;
        #2;
        chk("rst_txd", txd, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_err", rx_err, 0);
        chk("rst_rxdata", rxdata, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        tick(2);

        // 8N1 frame of 0xA5: latency and bit timing
        txdata = 8'hA5; write_tx = 1'b1;
        tick();
        write_tx = 1'b0;
        chk("tx_lat_1clk", txd, 1);
        tick();
        chk("tx_lat_2clk", txd, 0);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 16; c++) begin
                if (b != 0 || c != 0) tick();
                chk("tx_a5_bit", txd, frame[b]);
                chk("tx_a5_busy", tx_busy, 1);
            end
        end
        tick();
        chk("tx_a5_end_busy", tx_busy, 0);
        chk("tx_a5_end_txd", txd, 1);

        // Even parity loopback of 0x07
        parity_mode = 2'b10; loop_en = 1'b1;
        sb_q.push_back({2'b00, 8'h07});
        txdata = 8'h07; write_tx = 1'b1;
        tick();
        write_tx = 1'b0;
        t = 0;
        while (txd && t < 10) begin tick(); t++; end
        tick(9 * 16 + 8);
        chk("par_even_bit", txd, 1);
        t = 0;
        while (!rx_valid && t < 400) begin tick(); t++; end
        chk("par_rx_level", rx_level, 1);
        chk("par_rx_err", rx_err, 0);
        pop_check("par_loop");
        wait_tx_idle("par_tx_idle");
        loop_en = 1'b0; parity_mode = 2'b00;
        tick(4);

        // Overrun: 5 frames into a 4-deep RX FIFO
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb_q.push_back({2'b00, 8'(8'h11 + i)});
            send_rx(8'(8'h11 + i), 1'b1);
            tick(4);
        end
        chk("ovr_level", rx_level, 4);
        chk("ovr_flag", rx_err[2], 1);
        for (int i = 0; i < 4; i++) pop_check("ovr_pop");
        chk("ovr_level_empty", rx_level, 0);
        chk("ovr_flag_kept", rx_err[2], 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("ovr_cleared", rx_err[2], 0);

        // Framing error on 0x55
        sb_q.push_back({2'b01, 8'h55});
        send_rx(8'h55, 1'b0);
        tick(4);
        pop_check("ferr");

        // Break: 12 bit times low
        rxd_drv = 1'b0;
        tick(12 * 16);
        rxd_drv = 1'b1;
        tick(4);
        chk("brk_flag", rx_err[3], 1);
        chk("brk_no_push", rx_level, 0);
        sb_q.push_back({2'b00, 8'h3C});
        send_rx(8'h3C, 1'b1);
        tick(4);
        pop_check("brk_rearm");
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("brk_cleared", rx_err, 0);

        // False start: 3-clock glitch
        rxd_drv = 1'b0;
        tick(3);
        rxd_drv = 1'b1;
        tick(40);
        chk("glitch_level", rx_level, 0);
        chk("glitch_valid", rx_valid, 0);

        // TX FIFO fill with tx_en=0, 9th write lost
        tx_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            txdata = 8'(8'h80 + i); write_tx = 1'b1;
            tick();
        end
        write_tx = 1'b0;
        chk("txf_full", tx_full, 1);
        chk("txf_level", tx_level, 8);
        chk("txf_idle", tx_busy, 0);
        loop_en = 1'b1;
        for (int i = 0; i < 8; i++) sb_q.push_back({2'b00, 8'(8'h80 + i)});
        tx_en = 1'b1;
        busy_cnt = 0; n_rd = 0; started = 1'b0; done = 1'b0; t = 0;
        while (t < 3000 && !(done && t > 0)) begin
            if (rx_valid && !read_rx) begin
                if (sb_q.size() > 0) e = sb_q.pop_front();
                else e = 'x;
                chk("b2b_data", rxdata, e[DATA_W-1:0]);
                chk("b2b_err", rx_err[1:0], e[DATA_W+1:DATA_W]);
                read_rx = 1'b1;
                n_rd++;
            end else begin
                read_rx = 1'b0;
            end
            tick();
            t++;
            if (tx_busy) begin
                busy_cnt++;
                started = 1'b1;
            end else if (started) begin
                done = 1'b1;
            end
        end
        for (int k = 0; k < 20; k++) begin
            if (rx_valid && !read_rx) begin
                if (sb_q.size() > 0) e = sb_q.pop_front();
                else e = 'x;
                chk("b2b_data", rxdata, e[DATA_W-1:0]);
                read_rx = 1'b1;
                n_rd++;
            end else begin
                read_rx = 1'b0;
            end
            tick();
        end
        read_rx = 1'b0;
        chk("b2b_busy_cycles", busy_cnt, 8 * 160);
        chk("b2b_frames_rx", n_rd, 8);
        chk("b2b_tx_level", tx_level, 0);
        loop_en = 1'b0;

        // Reset in the middle of a TX frame
        txdata = 8'h5A; write_tx = 1'b1;
        tick();
        txdata = 8'h3C;
        tick();
        write_tx = 1'b0;
        tick(40);
        chk("rstmid_busy_before", tx_busy, 1);
        chk("rstmid_level_before", tx_level, 1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_txd", txd, 1);
        chk("rstmid_tx_level", tx_level, 0);
        chk("rstmid_busy", tx_busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(2);
        chk("rstmid_after_txd", txd, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_fifo_n.md
Name: uart_fifo_n

Overview:
Parametrised next-generation UART for the serial peripheral subsystem.
- Configurable data width (5-8 bits), parity modes, 1 or 2 stop bits.
- Independent RX and TX FIFOs with level outputs.
- Per-entry error flags, plus break detection and a sticky overrun flag.
- Sits between the CPU-side register block, which drives control and FIFO strobes, and the pad rxd/txd.

Parameters:
DATA_W, 8, data bits per character, legal 5..8
RX_DEPTH, 8, RX FIFO entries, power of 2, >=2
TX_DEPTH, 8, TX FIFO entries, power of 2, >=2
CNT_W, 16, baud divisor width

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
rxd  in  1  serial input (asynchronous, idle 1)
txd  out  1  serial output, registered
baudrate  in  CNT_W  bit period = baudrate+1 clocks; minimum legal value 3
parity_mode  in  2  00 none, 01 odd, 10 even, 11 stick (parity bit = stick_bit)
stick_bit  in  1  parity bit value sent and expected in mode 11
two_stop  in  1  TX sends 2 stop bits; RX checks only the first
rx_en  in  1  enable receiver
tx_en  in  1  enable transmitter pops
txdata  in  DATA_W  TX write data
write_tx  in  1  push txdata into TX FIFO
tx_full  out  1  TX FIFO full
tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
tx_busy  out  1  frame in progress on txd
rxdata  out  DATA_W  RX FIFO head data
rx_valid  out  1  RX FIFO non-empty
read_rx  in  1  pop RX FIFO head
rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
rx_err  out  4  {break, overrun, parity, framing}; [1:0] belong to head entry, [3:2] sticky
clear_err  in  1  clear sticky break/overrun

Behaviour:
- Reset values:
  - txd=1; tx_busy=0; both FIFOs empty, so levels=0, rx_valid=0, tx_full=0.
  - rx_err=0; rxdata=0.
  - Both FSMs return to IDLE.
- rxd passes through a 2-flop synchroniser; all RX decisions use the synchronised value.
- Bit counter runs 0..baudrate, then wraps to 0. Mid-bit sample point is count==baudrate>>1.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE->START on a synchronised 1->0 transition while rx_en=1; the counter is cleared.
  - START: if the mid-bit sample is 1, treat as a false start and return to IDLE with nothing pushed.
  - DATA: sample DATA_W bits, LSB first.
  - PARITY: present only if parity_mode!=00. Parity error = received bit != expected bit (odd: data XOR parity = 1; even: data XOR parity = 0; stick: parity = stick_bit).
  - STOP: sampled at mid-bit; 0 means a framing error.
  - Break: data==0, parity bit (if any)==0 and stop==0. On break, set sticky break, push nothing, go to BREAK_WAIT until the synchronised rxd is 1, then IDLE.
  - Otherwise push {parity_err, framing_err, data} at the stop-bit mid-sample and go to IDLE. The next start edge can be detected on the following cycle.
  - Push with RX FIFO full (and no read_rx that cycle): word dropped, sticky overrun set. push+read_rx on a full FIFO is accepted.
  - rx_en=0 mid-frame aborts the frame with nothing pushed. The FIFO contents are kept.
- TX FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE with tx_en=1 and FIFO non-empty: pop and load the shifter. txd goes low on the next clock.
  - Latency: write_tx to an empty FIFO while idle makes txd go low exactly 2 clocks later.
  - Each bit is held for baudrate+1 clocks. LSB first, then parity if enabled, then 1 or 2 stop bits.
  - tx_busy=1 from START through the last stop bit.
  - tx_en=0 mid-frame completes the current frame; no new pops follow.
- Frames run back-to-back with no idle gap if the FIFO is non-empty at the end of the stop bit.
- FIFO rules:
  - write_tx when full: ignored, data lost, no flag.
  - read_rx when empty: ignored.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo DEPTH; the level counter has one extra bit, so full is level==DEPTH.
- Stick parity on TX sends stick_bit.
- Changing baudrate, parity_mode or two_stop mid-frame is undefined; software idles the block first.
- clear_err clears bits [3:2] the cycle after. If it coincides with a new overrun or break event, the set wins.
- Reset asserted mid-operation: immediately txd=1, frames aborted, FIFOs emptied.

Decomposition:
- Package uart_pkg holds:
  - parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN, PAR_STICK;
  - RX and TX state enums;
  - rx_err bit index constants.
- Sub-module uart_sync_fifo (params WIDTH, DEPTH) is instantiated twice: RX with WIDTH=DATA_W+2, TX with WIDTH=DATA_W.
- It provides push, pop, full, empty, level and a registered head output.

Test Plan:
- baudrate=15, 8N1, write 0xA5 -> txd low 2 clocks after write_tx; bits 0,1,0,1,0,0,1,0,1,1, each held 16 clocks; tx_busy high for 160 clocks.
- Even parity, loopback txd->rxd, send 0x07 -> parity bit 1; rxdata=0x07, rx_err=0000, rx_level=1.
- RX_DEPTH=4, 5 frames 0x11..0x15 with no reads -> rx_level=4, rx_err[2]=1; pops return 0x11..0x14; clear_err clears bit 2.
- Drive 0x55 with stop bit 0 -> entry pushed, rx_err[0]=1. Hold rxd low for 12 bit times -> rx_err[3]=1, nothing pushed, receiver re-arms after rxd returns high.
- tx_en=0, TX_DEPTH=8, write 9 words -> tx_full=1, tx_level=8, 9th lost. Then tx_en=1 -> 8 back-to-back frames with no idle gap.
- Start glitch: rxd low for 3 clocks with baudrate=15 -> false start, no push. Then reset mid-TX-frame -> txd=1 in the same cycle, tx_level=0.
